alu_muldiv_control: RTL and testbench

ALU_MULDIV_CONTROL -- requirements
Module: alu_muldiv_control

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/muldiv_iter.sv | 110 +++++++++++
 rtl/alu_muldiv_control.sv | 164 ++++++++++++++++
 tb/tb_alu_muldiv_control.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings: ALUOp classes, funct codes, ALU opcodes and
// the multiply/divide sequencer state encoding.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    // mult/multu/div/divu share the 0110xx pattern
    function automatic logic is_muldiv(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned-magnitude multiply / restoring divide engine with a
// combinational sign-correction stage read out during the FIX cycle.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;

    logic             div_zero;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH-1:0] prod;

    // Divide-by-zero runs unsigned on the raw operands: the restoring loop
    // then naturally yields quotient all-ones and remainder = dividend.
    assign div_zero = is_div_i && (op_b_i == '0);
    assign a_neg    = is_signed_i && !div_zero && op_a_i[WIDTH-1];
    assign b_neg    = is_signed_i && !div_zero && op_b_i[WIDTH-1];
    assign mag_a    = a_neg ? (~op_a_i + 1'b1) : op_a_i;
    assign mag_b    = b_neg ? (~op_b_i + 1'b1) : op_b_i;

    assign sum     = {1'b0, acc_q} + {1'b0, opb_q};
    assign shifted = {acc_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, opb_q};

    always_comb begin
        acc_d  = acc_q;
        quo_d  = quo_q;
        opb_d  = opb_q;
        div_d  = div_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        if (load_i) begin
            acc_d  = '0;
            quo_d  = mag_a;
            opb_d  = mag_b;
            div_d  = is_div_i;
            neg_d  = a_neg ^ b_neg;
            rneg_d = is_div_i ? a_neg : (a_neg ^ b_neg);
        end else if (step_i) begin
            if (div_q) begin
                if (shifted >= {1'b0, opb_q}) begin
                    acc_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (quo_q[0]) begin
                    acc_d = sum[WIDTH:1];
                    quo_d = {sum[0], quo_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[WIDTH-1:1]};
                    quo_d = {acc_q[0], quo_q[WIDTH-1:1]};
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            quo_q  <= '0;
            opb_q  <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            quo_q  <= quo_d;
            opb_q  <= opb_d;
            div_q  <= div_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
        end
    end

    assign prod = neg_q ? (~{acc_q, quo_q} + 1'b1) : {acc_q, quo_q};

    always_comb begin
        if (div_q) begin
            res_lo_o = neg_q  ? (~quo_q + 1'b1) : quo_q;
            res_hi_o = rneg_q ? (~acc_q + 1'b1) : acc_q;
        end else begin
            res_lo_o = prod[WIDTH-1:0];
            res_hi_o = prod[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/alu_muldiv_control.sv
// ALU control decode plus the HI/LO multiply/divide sequencer.
// state | meaning
// IDLE  | accepting issue; mthi/mtlo write directly
// MUL   | WIDTH shift-add steps in muldiv_iter
// DIV   | WIDTH restoring shift-subtract steps in muldiv_iter
// FIX   | sign correction; hi/lo written on the edge leaving this state
module alu_muldiv_control
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic             issue,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [3:0]       operation,
    output logic             jrEnable,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_result,
    output logic             mf_select
);

    localparam int CW = $clog2(WIDTH);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             rtype;
    logic             md_issue;
    logic             load;
    logic             step;
    logic             fix_wr;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign rtype    = (ALUOp == ALUOP_RTYPE);
    assign md_issue = issue && rtype && is_muldiv(funct);

    always_comb begin
        operation = OP_AND;
        jrEnable  = 1'b0;
        case (ALUOp)
            ALUOP_ADD: operation = OP_ADD;
            ALUOP_SUB: operation = OP_SUB;
            ALUOP_AND: operation = OP_AND;
            default: begin
                case (funct)
                    FN_ADD: operation = OP_ADD;
                    FN_SUB: operation = OP_SUB;
                    FN_AND: operation = OP_AND;
                    FN_OR:  operation = OP_OR;
                    FN_NOR: operation = OP_NOR;
                    FN_SLT: operation = OP_SLT;
                    FN_JR: begin
                        operation = OP_ADD;
                        jrEnable  = 1'b1;
                    end
                    default: operation = OP_AND;
                endcase
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (md_issue) state_d = funct[1] ? ST_DIV : ST_MUL;
            ST_MUL,
            ST_DIV:  if (cnt_q == '0) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != ST_IDLE);
        load   = (state_q == ST_IDLE) && md_issue;
        step   = (state_q == ST_MUL) || (state_q == ST_DIV);
        fix_wr = (state_q == ST_FIX);
    end

    // Step down-counter: loaded with WIDTH-1, terminal count selects FIX
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(WIDTH - 1);
        end else if (step && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv_iter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (load),
        .step_i     (step),
        .is_div_i   (funct[1]),
        .is_signed_i(~funct[0]),
        .op_a_i     (rs_data),
        .op_b_i     (rt_data),
        .res_hi_o   (res_hi),
        .res_lo_o   (res_lo)
    );

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (fix_wr) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end else if (!busy && issue && rtype) begin
            if (funct == FN_MTHI) hi_d = rs_data;
            if (funct == FN_MTLO) lo_d = rs_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

    always_comb begin
        mf_select = 1'b0;
        mf_result = '0;
        if (rtype && funct == FN_MFHI) begin
            mf_select = 1'b1;
            mf_result = hi_q;
        end else if (rtype && funct == FN_MFLO) begin
            mf_select = 1'b1;
            mf_result = lo_q;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_control.sv
// Bench for alu_muldiv_control: decode table, scoreboarded mul/div/mt ops,
// issue-while-busy and mid-operation reset.
module tb_alu_muldiv_control;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   ALUOp = 2'b00;
    logic [5:0]   funct = 6'b0;
    logic         issue = 1'b0;
    logic [W-1:0] rs_data = '0;
    logic [W-1:0] rt_data = '0;
    logic [3:0]   operation;
    logic         jrEnable;
    logic         busy;
    logic [W-1:0] hi, lo, mf_result;
    logic         mf_select;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    alu_muldiv_control #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ALUOp    (ALUOp),
        .funct    (funct),
        .issue    (issue),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .operation(operation),
        .jrEnable (jrEnable),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .mf_result(mf_result),
        .mf_select(mf_select)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb_, p;
        int     q, r;
        logic [63:0] up;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (f)
            FN_MULT: begin
                p = sa * sb_;
                return p;
            end
            FN_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                return up;
            end
            FN_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // inject: 0 none, 1 second mult mid-flight, 2 mthi mid-flight
    task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int inject);
        logic [63:0] m;
        exp_t e;
        int cnt;
        m = model(f, a, b);
        sb.push_back('{hi: m[63:32], lo: m[31:0]});
        @(negedge clock);
        ALUOp = ALUOP_RTYPE; funct = f; rs_data = a; rt_data = b; issue = 1'b1;
        @(negedge clock);
        issue = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            if (cnt == 5 && inject == 1) begin
                funct = FN_MULT; rs_data = 32'h1234_5678; rt_data = 32'h0000_0100; issue = 1'b1;
            end else if (cnt == 5 && inject == 2) begin
                funct = FN_MTHI; rs_data = 32'hDEAD_BEEF; issue = 1'b1;
            end else if (cnt == 6) begin
                issue = 1'b0;
            end
            @(negedge clock);
        end
        issue = 1'b0;
        check({tag, "_busy_cycles"}, 64'(cnt), 64'(W + 1));
        e = sb.pop_front();
        check({tag, "_hi"}, 64'(hi), 64'(e.hi));
        check({tag, "_lo"}, 64'(lo), 64'(e.lo));
        ALUOp = ALUOP_RTYPE; funct = FN_MFLO; issue = 1'b1;
        #1;
        check({tag, "_mflo"}, {31'b0, mf_select, mf_result}, {31'b0, 1'b1, e.lo});
        funct = FN_MFHI;
        #1;
        check({tag, "_mfhi"}, {31'b0, mf_select, mf_result}, {31'b0, 1'b1, e.hi});
        issue = 1'b0;
    endtask

    task automatic run_mt(input string tag, input logic [5:0] f, input logic [W-1:0] a);
        exp_t e;
        e = sb.size() == 0 ? '{hi: hi, lo: lo} : sb[$];
        @(negedge clock);
        if (f == FN_MTHI) sb.push_back('{hi: a, lo: e.lo});
        else              sb.push_back('{hi: e.hi, lo: a});
        ALUOp = ALUOP_RTYPE; funct = f; rs_data = a; issue = 1'b1;
        @(negedge clock);
        issue = 1'b0;
        e = sb.pop_front();
        check({tag, "_hi"}, 64'(hi), 64'(e.hi));
        check({tag, "_lo"}, 64'(lo), 64'(e.lo));
    endtask

    logic [7:0] dec_in  [12] = '{8'b00_000000, 8'b01_000000, 8'b11_000000, 8'b00_001000,
                                 8'b10_100000, 8'b10_100010, 8'b10_100100, 8'b10_100101,
                                 8'b10_100111, 8'b10_101010, 8'b10_001000, 8'b10_111111};
    logic [4:0] dec_exp [12] = '{5'b0_0010, 5'b0_0110, 5'b0_0000, 5'b0_0010,
                                 5'b0_0010, 5'b0_0110, 5'b0_0000, 5'b0_0001,
                                 5'b0_1100, 5'b0_0111, 5'b1_0010, 5'b0_0000};

    logic [5:0] md_codes [4] = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};

    initial begin
        logic [5:0]   f;
        logic [W-1:0] a, b;
        int cnt;

        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        ALUOp = ALUOP_RTYPE; funct = FN_MFHI;
        #1;
        check("rst_mf", {31'b0, mf_select, mf_result}, {31'b0, 1'b1, 32'b0});
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            ALUOp = dec_in[i][7:6];
            funct = dec_in[i][5:0];
            #1;
            check($sformatf("dec%0d", i), {59'b0, jrEnable, operation}, {59'b0, dec_exp[i]});
        end
        ALUOp = ALUOP_ADD; funct = FN_MFLO;
        #1;
        check("mfsel_non_rtype", 64'(mf_select), 64'd0);

        run_op("mult_neg", FN_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 0);
        run_op("divu", FN_DIVU, 32'd100, 32'd7, 0);
        run_op("div_neg", FN_DIV, -32'sd7, 32'd2, 0);
        run_op("div_zero", FN_DIV, 32'd5, 32'd0, 0);
        run_op("divu_zero", FN_DIVU, 32'h8000_0003, 32'd0, 0);
        run_op("multu_big", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mult_busy_issue", FN_MULT, 32'h0000_0321, 32'hFFFF_F000, 1);
        run_op("div_busy_mthi", FN_DIV, 32'd1000, -32'sd33, 2);
        run_mt("mtlo", FN_MTLO, 32'h5555_AAAA);

        for (int i = 0; i < 8; i++) begin
            f = md_codes[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            if (i % 2 == 1) b = b >> $urandom_range(8, 28);
            if (f == FN_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            run_op($sformatf("rnd%0d", i), f, a, b, 0);
        end

        // Reset ten cycles into a multu
        @(negedge clock);
        ALUOp = ALUOP_RTYPE; funct = FN_MULTU; rs_data = 32'hFFFF_0000; rt_data = 32'h0001_0001;
        issue = 1'b1;
        @(negedge clock);
        issue = 1'b0;
        cnt = 0;
        while (cnt < 9) begin
            cnt++;
            @(negedge clock);
        end
        check("pre_rst_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        funct = FN_MTHI; rs_data = 32'hABCD_1234; issue = 1'b1;
        @(negedge clock);
        issue = 1'b0;
        check("post_rst_mthi_hi", 64'(hi), 64'hABCD_1234);
        check("post_rst_mthi_lo", 64'(lo), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clock);
        check("post_rst_hold_hi", 64'(hi), 64'hABCD_1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
